// File: rtl/params_pkg.sv
// Shared sizing, tag and entry types for the reorder buffer and its arbiter.
package params_pkg;

  localparam int unsigned REGISTER_WIDTH = 5;
  localparam int unsigned ROB_ENTRIES    = 8;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned IDX_W          = $clog2(ROB_ENTRIES);

  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      reg_wr_en;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/wb_arbiter.sv
// Single ROB write port arbiter: EX wins by default, ALU gets priority after
// STARVE_LIMIT consecutive denials.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic alu_wb_req_i,
  input  logic ex_wb_req_i,
  output logic alu_allowed_wb_o,
  output logic ex_allowed_wb_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             alu_prio;

  assign alu_prio         = (starve_cnt >= LIMIT);
  assign ex_allowed_wb_o  = !(alu_prio && alu_wb_req_i);
  assign alu_allowed_wb_o = !ex_wb_req_i || alu_prio;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (alu_wb_req_i && !alu_allowed_wb_o) begin
      starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: decode allocates, ALU/MEM and EX write back,
// entries retire to the regfile in program order.
module reorder_buffer #(
  parameter int unsigned ROB_ENTRIES    = params_pkg::ROB_ENTRIES,
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_valid_i,
  input  logic                          alloc_reg_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0]     alloc_wr_reg_i,
  output logic [$clog2(ROB_ENTRIES)-1:0] alloc_idx_o,
  output logic                          rob_is_full_o,
  input  logic                          alu_wb_req_i,
  input  logic [$clog2(ROB_ENTRIES)-1:0] alu_wb_idx_i,
  input  logic [DATA_WIDTH-1:0]         alu_wb_data_i,
  output logic                          alu_allowed_wb_o,
  input  logic                          ex_wb_req_i,
  input  logic [$clog2(ROB_ENTRIES)-1:0] ex_wb_idx_i,
  input  logic [DATA_WIDTH-1:0]         ex_wb_data_i,
  output logic                          ex_allowed_wb_o,
  input  logic                          flush_i,
  input  logic [$clog2(ROB_ENTRIES)-1:0] flush_idx_i,
  output logic                          commit_valid_o,
  output logic                          commit_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0]     commit_wr_reg_o,
  output logic [DATA_WIDTH-1:0]         commit_data_o
);

  import params_pkg::*;

  localparam int unsigned IDX_W = $clog2(ROB_ENTRIES);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(ROB_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;

  rob_entry_t entries [ROB_ENTRIES];
  idx_t           head;
  idx_t           tail;
  logic [IDX_W:0] count;

  logic                   full;
  logic                   alloc_fire;
  logic                   commit_fire;
  logic                   wb_fire;
  idx_t                   wb_idx;
  logic [DATA_WIDTH-1:0]  wb_data;
  idx_t                   flush_span;
  logic [ROB_ENTRIES-1:0] squash;

  assign full        = (count == FULL_COUNT);
  assign alloc_fire  = alloc_valid_i && !full && !flush_i;
  assign commit_fire = entries[head].valid && entries[head].done;

  wb_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wb_arbiter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alu_wb_req_i    (alu_wb_req_i),
    .ex_wb_req_i     (ex_wb_req_i),
    .alu_allowed_wb_o(alu_allowed_wb_o),
    .ex_allowed_wb_o (ex_allowed_wb_o)
  );

  always_comb begin
    wb_fire = 1'b0;
    wb_idx  = alu_wb_idx_i;
    wb_data = alu_wb_data_i;
    if (ex_wb_req_i && ex_allowed_wb_o) begin
      wb_fire = 1'b1;
      wb_idx  = ex_wb_idx_i;
      wb_data = ex_wb_data_i;
    end else if (alu_wb_req_i && alu_allowed_wb_o) begin
      wb_fire = 1'b1;
    end
  end

  // Age is measured as distance from head, so the wrap needs no special case.
  always_comb begin
    flush_span = flush_idx_i - head;
    squash     = '0;
    for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
      squash[i] = flush_i && ((idx_t'(i) - head) > flush_span);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (commit_fire) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (wb_fire && entries[wb_idx].valid && !squash[wb_idx]) begin
        entries[wb_idx].done <= 1'b1;
        entries[wb_idx].data <= wb_data;
      end
      if (alloc_fire) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, reg_wr_en: alloc_reg_wr_en_i,
                           wr_reg: alloc_wr_reg_i, data: '0};
        tail          <= tail + 1'b1;
      end
      for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
        if (squash[i]) entries[i].valid <= 1'b0;
      end
      if (flush_i) begin
        tail  <= flush_idx_i + 1'b1;
        count <= (IDX_W + 1)'(flush_span) + 1'b1 - (IDX_W + 1)'(commit_fire);
      end else begin
        count <= count + (IDX_W + 1)'(alloc_fire) - (IDX_W + 1)'(commit_fire);
      end
    end
  end

  assign alloc_idx_o        = tail;
  assign rob_is_full_o      = full;
  assign commit_valid_o     = commit_fire;
  assign commit_reg_wr_en_o = commit_fire && entries[head].reg_wr_en;
  assign commit_wr_reg_o    = commit_fire ? entries[head].wr_reg : '0;
  assign commit_data_o      = commit_fire ? entries[head].data : '0;

  a_alloc_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(alloc_valid_i && full))
    else $warning("reorder_buffer: allocation while full was dropped");

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer.
module tb_reorder_buffer;

  import params_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned RW = params_pkg::REGISTER_WIDTH;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_wr_en;
  logic [RW-1:0] alloc_reg;
  logic [IW-1:0] alloc_idx;
  logic          full;
  logic          alu_req, ex_req;
  logic [IW-1:0] alu_idx, ex_idx;
  logic [DW-1:0] alu_data, ex_data;
  logic          alu_allowed, ex_allowed;
  logic          flush;
  logic [IW-1:0] flush_idx;
  logic          commit_valid, commit_wr_en;
  logic [RW-1:0] commit_reg;
  logic [DW-1:0] commit_data;

  always #5 clk = ~clk;

  reorder_buffer #(
    .ROB_ENTRIES   (N),
    .DATA_WIDTH    (DW),
    .REGISTER_WIDTH(RW),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .alloc_valid_i     (alloc_valid),
    .alloc_reg_wr_en_i (alloc_wr_en),
    .alloc_wr_reg_i    (alloc_reg),
    .alloc_idx_o       (alloc_idx),
    .rob_is_full_o     (full),
    .alu_wb_req_i      (alu_req),
    .alu_wb_idx_i      (alu_idx),
    .alu_wb_data_i     (alu_data),
    .alu_allowed_wb_o  (alu_allowed),
    .ex_wb_req_i       (ex_req),
    .ex_wb_idx_i       (ex_idx),
    .ex_wb_data_i      (ex_data),
    .ex_allowed_wb_o   (ex_allowed),
    .flush_i           (flush),
    .flush_idx_i       (flush_idx),
    .commit_valid_o    (commit_valid),
    .commit_reg_wr_en_o(commit_wr_en),
    .commit_wr_reg_o   (commit_reg),
    .commit_data_o     (commit_data)
  );

  typedef struct packed {
    logic          wr_en;
    logic [RW-1:0] rg;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check any retirement against the scoreboard, then step to posedge+1.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (commit_valid) begin
        if (sb.size() == 0) begin
          chk("commit_unexpected", 64'(commit_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("commit", 64'({commit_wr_en, commit_reg, commit_data}), 64'(e));
        end
      end else begin
        chk("commit_idle_zero", 64'({commit_wr_en, commit_reg, commit_data}), 64'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_wr_en = 1'b0; alloc_reg = '0;
    alu_req = 1'b0; alu_idx = '0; alu_data = '0;
    ex_req = 1'b0; ex_idx = '0; ex_data = '0;
    flush = 1'b0; flush_idx = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic wr_en, input int rg, input logic [DW-1:0] d, input bit accept);
    alloc_valid = 1'b1;
    alloc_wr_en = wr_en;
    alloc_reg   = RW'(rg);
    if (accept) sb.push_back('{wr_en: wr_en, rg: RW'(rg), data: d});
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic wb_alu(input int tag, input logic [DW-1:0] d);
    alu_req = 1'b1; alu_idx = IW'(tag); alu_data = d;
    cyc();
    alu_req = 1'b0;
  endtask

  task automatic wb_ex(input int tag, input logic [DW-1:0] d);
    ex_req = 1'b1; ex_idx = IW'(tag); ex_data = d;
    cyc();
    ex_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) cyc();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tag;
    rst = 1'b1;
    idle();

    // 1: reset state, then out-of-order WB retires in program order
    do_reset();
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    chk("rst_alu_allowed", 64'(alu_allowed), 64'd1);
    chk("rst_ex_allowed", 64'(ex_allowed), 64'd1);
    chk("rst_commit_data", 64'({commit_wr_en, commit_reg, commit_data}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_alloc_idx", 64'(alloc_idx), 64'(i));
      alloc(1'b1, i + 1, DW'(32'h1111 * (i + 1)), 1'b1);
    end
    alu_req = 1'b1; alu_idx = 3'd2; alu_data = 32'h3333;
    #1;
    chk("t1_alu_grant", 64'(alu_allowed), 64'd1);
    chk("t1_no_commit_wb2", 64'(commit_valid), 64'd0);
    cyc();
    alu_idx = 3'd0; alu_data = 32'h1111;
    #1;
    chk("t1_no_commit_wb0", 64'(commit_valid), 64'd0);
    cyc();
    alu_idx = 3'd1; alu_data = 32'h2222;
    cyc();
    alu_req = 1'b0;
    drain("t1_drain");

    // 2: fill to full, drop the 9th alloc, commit-while-full drops the alloc
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(1'b1, i + 8, DW'(32'hB000 + i), 1'b1);
      chk("t2_full", 64'(full), 64'(i == 7));
    end
    alloc(1'b1, 20, 32'hBAD0, 1'b0);
    chk("t2_tail_stays", 64'(alloc_idx), 64'd0);
    chk("t2_still_full", 64'(full), 64'd1);
    wb_alu(0, 32'hB000);
    alloc_valid = 1'b1; alloc_reg = RW'(21);
    #1;
    chk("t2_full_no_bypass", 64'(full), 64'd1);
    chk("t2_commit_head", 64'(commit_valid), 64'd1);
    cyc();
    alloc_valid = 1'b0;
    chk("t2_full_clears", 64'(full), 64'd0);
    chk("t2_alloc_dropped", 64'(alloc_idx), 64'd0);

    // 3: starvation counter hands the port to ALU after 4 denials
    do_reset();
    alu_req = 1'b1; ex_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("t3_ex_grant", 64'(ex_allowed), 64'(c != 5));
      chk("t3_alu_grant", 64'(alu_allowed), 64'(c == 5));
      cyc();
    end
    alu_req = 1'b0;
    #1;
    chk("t3_exonly_alu", 64'(alu_allowed), 64'd0);
    chk("t3_exonly_ex", 64'(ex_allowed), 64'd1);
    cyc();
    alu_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("t3b_ex_grant", 64'(ex_allowed), 64'(c != 5));
      chk("t3b_alu_grant", 64'(alu_allowed), 64'(c == 5));
      cyc();
    end
    ex_req = 1'b0;
    #1;
    chk("t3_aluonly_alu", 64'(alu_allowed), 64'd1);
    chk("t3_aluonly_ex", 64'(ex_allowed), 64'd1);
    idle();
    cyc();

    // 4: wrapped flush at tag 0 with head=6
    do_reset();
    for (int i = 0; i < 6; i++) alloc(1'b1, 10 + i, DW'(32'hC000 + i), 1'b1);
    for (int i = 0; i < 6; i++) wb_ex(i, DW'(32'hC000 + i));
    drain("t4_predrain");
    for (int k = 0; k < 6; k++) begin
      tag = (6 + k) % 8;
      chk("t4_alloc_idx", 64'(alloc_idx), 64'(tag));
      alloc(1'b0, 16 + k, DW'(32'hD000 + tag), 1'b1);
    end
    flush = 1'b1; flush_idx = 3'd0;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    chk("t4_tail_after_flush", 64'(alloc_idx), 64'd1);
    wb_alu(2, 32'hDEAD);
    for (int k = 0; k < 5; k++) begin
      alloc(1'b1, 24 + k, DW'(32'hE000 + 1 + k), 1'b1);
      chk("t4_refill_full", 64'(full), 64'(k == 4));
    end
    for (int k = 0; k < 8; k++) begin
      tag = (6 + k) % 8;
      wb_alu(tag, (k < 3) ? DW'(32'hD000 + tag) : DW'(32'hE000 + tag));
    end
    drain("t4_drain");

    // 5: flush + alloc + head commit in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) alloc(1'b1, 3 + i, DW'(32'hF000 + i), 1'b1);
    wb_alu(0, 32'hF000);
    flush = 1'b1; flush_idx = 3'd1; alloc_valid = 1'b1; alloc_reg = RW'(30);
    #1;
    chk("t5_commit_with_flush", 64'(commit_valid), 64'd1);
    cyc();
    flush = 1'b0; alloc_valid = 1'b0;
    void'(sb.pop_back());
    chk("t5_tail", 64'(alloc_idx), 64'd2);
    for (int k = 0; k < 7; k++) begin
      alloc(1'b1, 8 + k, DW'(32'hF100 + k), 1'b1);
      chk("t5_count_full", 64'(full), 64'(k == 6));
    end
    wb_ex(1, 32'hF001);
    for (int k = 0; k < 7; k++) wb_ex((2 + k) % 8, DW'(32'hF100 + k));
    drain("t5_drain");

    // 6: reset with entries in flight and a pending WB
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1, 1 + i, DW'(32'hA500 + i), 1'b1);
    rst = 1'b1; alu_req = 1'b1; alu_idx = 3'd0; alu_data = 32'h5A5A;
    cyc();
    rst = 1'b0; alu_req = 1'b0;
    sb.delete();
    chk("t6_commit_valid", 64'(commit_valid), 64'd0);
    chk("t6_full", 64'(full), 64'd0);
    chk("t6_alloc_idx", 64'(alloc_idx), 64'd0);
    repeat (3) cyc();
    for (int k = 0; k < 8; k++) begin
      alloc(1'b0, 2, DW'(32'h6000 + k), 1'b1);
      chk("t6_count_full", 64'(full), 64'(k == 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
